// File: rtl/m68k_bus_responder.sv
// -----------------------------------------------------------------------------
// m68k_bus_responder
//
// Purpose:
//   Asynchronous 68000 bus slave that exposes a 32-byte window of sixteen
//   16-bit registers at BASE_ADDR. Strobes and RW are brought into the PI_CLK
//   domain through 2-flop synchronizers; a single FSM walks every bus cycle
//   through STROBE -> DECODE -> WAIT -> ACK (or IGNORE on an address miss).
//   Word 15 is a read-only ID word (16'h5053); writing it is a protection
//   violation.
//
// Build option:
//   M68K_RESP_BERR_EN  defined   -> protection violation answered with BERR_n.
//                      undefined -> no BERR state, BERR_n tied high, the
//                                   violating write is acknowledged with
//                                   DTACK_n and its data discarded.
//
// Parameters:
//   BASE_ADDR    byte base of the register window (bits 4:0 zero)
//   WAIT_CYCLES  PI_CLK cycles spent in WAIT before acknowledging (0..15)
//
// Ports:
//   PI_CLK        in   sole clock
//   RESET         in   synchronous active-high reset
//   M68K_A        in   address bits 23:1
//   M68K_D_IN     in   write data from the bus
//   M68K_D_OUT    out  read data to the bus
//   M68K_D_OE     out  high while M68K_D_OUT should be driven
//   M68K_AS_n     in   address strobe (asynchronous)
//   M68K_UDS_n    in   upper data strobe (asynchronous)
//   M68K_LDS_n    in   lower data strobe (asynchronous)
//   M68K_RW       in   1 = read, 0 = write (asynchronous)
//   M68K_DTACK_n  out  data transfer acknowledge, active low
//   M68K_BERR_n   out  bus error, active low
//   ACCESS_CNT    out  number of acknowledged accesses (wraps)
// -----------------------------------------------------------------------------
module m68k_bus_responder #(
    parameter logic [23:0] BASE_ADDR   = 24'hDF0000,
    parameter int          WAIT_CYCLES = 4
) (
    input  logic        PI_CLK,
    input  logic        RESET,
    input  logic [23:1] M68K_A,
    input  logic [15:0] M68K_D_IN,
    output logic [15:0] M68K_D_OUT,
    output logic        M68K_D_OE,
    input  logic        M68K_AS_n,
    input  logic        M68K_UDS_n,
    input  logic        M68K_LDS_n,
    input  logic        M68K_RW,
    output logic        M68K_DTACK_n,
    output logic        M68K_BERR_n,
    output logic [15:0] ACCESS_CNT
);

    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [15:0] ID_WORD   = 16'h5053;
    localparam logic [3:0]  ID_INDEX  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_DECODE,
        S_WAIT,
        S_ACK,
        S_IGNORE
`ifdef M68K_RESP_BERR_EN
        ,
        S_BERR
`endif
    } state_t;

    // Byte-lane merge for partial writes: enabled lanes take new data,
    // disabled lanes keep the stored byte.
    function automatic logic [15:0] merge_bytes(input logic [15:0] old_w,
                                                input logic [15:0] new_w,
                                                input logic [1:0]  be);
        merge_bytes = {be[1] ? new_w[15:8] : old_w[15:8],
                       be[0] ? new_w[7:0]  : old_w[7:0]};
    endfunction

    // -------------------------------------------------------------------------
    // Input synchronizers: {AS_n, UDS_n, LDS_n, RW}. Reset to all ones so a
    // strobe already low when reset releases is seen as a fresh falling edge.
    // -------------------------------------------------------------------------
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    always_ff @(posedge PI_CLK) begin
        if (RESET) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= {M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW};
            sync2_q <= sync1_q;
        end
    end

    logic as_n_s;
    logic uds_n_s;
    logic lds_n_s;
    logic rw_s;

    assign as_n_s  = sync2_q[3];
    assign uds_n_s = sync2_q[2];
    assign lds_n_s = sync2_q[1];
    assign rw_s    = sync2_q[0];

    // -------------------------------------------------------------------------
    // Bus-cycle FSM, latched access attributes, register file, outputs
    // -------------------------------------------------------------------------
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  idx_q;
    logic        rw_q;
    logic [1:0]  be_q;
    logic [15:0] wdata_q;
    logic [15:0] regs_q [16];
    logic [15:0] dout_q;
    logic        d_oe_q;
    logic        dtack_n_q;
    logic [15:0] access_cnt_q;
`ifdef M68K_RESP_BERR_EN
    logic        berr_n_q;
`endif

    logic [15:0] rdata_d;
    logic [15:0] wmerge_d;
    logic        protect_d;
    logic        hit_d;

    always_comb begin
        rdata_d   = (idx_q == ID_INDEX) ? ID_WORD : regs_q[idx_q];
        wmerge_d  = merge_bytes(regs_q[idx_q], wdata_q, be_q);
        protect_d = !rw_q && (idx_q == ID_INDEX);
        hit_d     = (M68K_A[23:5] == BASE_ADDR[23:5]);
    end

    always_ff @(posedge PI_CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            idx_q        <= 4'd0;
            rw_q         <= 1'b1;
            be_q         <= 2'b00;
            wdata_q      <= 16'h0000;
            dout_q       <= 16'h0000;
            d_oe_q       <= 1'b0;
            dtack_n_q    <= 1'b1;
            access_cnt_q <= 16'h0000;
`ifdef M68K_RESP_BERR_EN
            berr_n_q     <= 1'b1;
`endif
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!as_n_s) begin
                        state_q <= S_STROBE;
                    end
                end

                // An aborted cycle (AS_n released before any data strobe)
                // takes priority over a late data strobe.
                S_STROBE: begin
                    if (as_n_s) begin
                        state_q <= S_IDLE;
                    end else if (!uds_n_s || !lds_n_s) begin
                        state_q <= S_DECODE;
                    end
                end

                // Address and write data are stable by now (the master set
                // them up before the strobes), so they are sampled directly.
                S_DECODE: begin
                    idx_q   <= M68K_A[4:1];
                    rw_q    <= rw_s;
                    be_q    <= {!uds_n_s, !lds_n_s};
                    wdata_q <= M68K_D_IN;
                    cnt_q   <= WAIT_INIT;
                    state_q <= hit_d ? S_WAIT : S_IGNORE;
                end

                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else
`ifdef M68K_RESP_BERR_EN
                    if (protect_d) begin
                        berr_n_q <= 1'b0;
                        state_q  <= S_BERR;
                    end else
`endif
                    begin
                        // Reads return the whole word regardless of which
                        // lanes were strobed; a write to the ID word is
                        // dropped but still acknowledged in this branch.
                        if (rw_q) begin
                            dout_q <= rdata_d;
                        end else if (!protect_d) begin
                            regs_q[idx_q] <= wmerge_d;
                        end
                        dtack_n_q    <= 1'b0;
                        d_oe_q       <= rw_q;
                        access_cnt_q <= access_cnt_q + 16'd1;
                        state_q      <= S_ACK;
                    end
                end

                S_ACK: begin
                    if (as_n_s) begin
                        dtack_n_q <= 1'b1;
                        d_oe_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end

`ifdef M68K_RESP_BERR_EN
                S_BERR: begin
                    if (as_n_s) begin
                        berr_n_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
`endif

                S_IGNORE: begin
                    if (as_n_s) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign M68K_D_OUT   = dout_q;
    assign M68K_D_OE    = d_oe_q;
    assign M68K_DTACK_n = dtack_n_q;
    assign ACCESS_CNT   = access_cnt_q;
`ifdef M68K_RESP_BERR_EN
    assign M68K_BERR_n  = berr_n_q;
`else
    assign M68K_BERR_n  = 1'b1;
`endif

endmodule

// File: tb/tb_m68k_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_m68k_bus_responder
//
// Directed bench for m68k_bus_responder (default parameters, WAIT_CYCLES = 4).
// Bus inputs change on the falling edge of PI_CLK; the next rising edge is the
// one that first samples them. With 2 sync flops + STROBE + DECODE + 4 WAIT +
// 1 the acknowledge appears 9 rising edges after that sampling edge.
// -----------------------------------------------------------------------------
module tb_m68k_bus_responder;

    localparam logic [23:0] BASE = 24'hDF0000;

    logic        PI_CLK;
    logic        RESET;
    logic [23:1] M68K_A;
    logic [15:0] M68K_D_IN;
    logic [15:0] M68K_D_OUT;
    logic        M68K_D_OE;
    logic        M68K_AS_n;
    logic        M68K_UDS_n;
    logic        M68K_LDS_n;
    logic        M68K_RW;
    logic        M68K_DTACK_n;
    logic        M68K_BERR_n;
    logic [15:0] ACCESS_CNT;

    m68k_bus_responder dut (
        .PI_CLK       (PI_CLK),
        .RESET        (RESET),
        .M68K_A       (M68K_A),
        .M68K_D_IN    (M68K_D_IN),
        .M68K_D_OUT   (M68K_D_OUT),
        .M68K_D_OE    (M68K_D_OE),
        .M68K_AS_n    (M68K_AS_n),
        .M68K_UDS_n   (M68K_UDS_n),
        .M68K_LDS_n   (M68K_LDS_n),
        .M68K_RW      (M68K_RW),
        .M68K_DTACK_n (M68K_DTACK_n),
        .M68K_BERR_n  (M68K_BERR_n),
        .ACCESS_CNT   (ACCESS_CNT)
    );

    initial PI_CLK = 1'b0;
    always #5 PI_CLK = ~PI_CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Results of the most recent bus cycle
    int          resp;      // 0 none, 1 DTACK, 2 BERR
    int          lat;
    int          rel;
    logic [15:0] rdata;
    logic        oe_ack;
    logic        oe_any;
    logic        both_low;
    logic        held;
    int          exp_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_cycle(input logic [23:0] addr, input logic rw,
                               input logic uds, input logic lds, input logic [15:0] wdata);
        @(negedge PI_CLK);
        M68K_A     = addr[23:1];
        M68K_D_IN  = wdata;
        M68K_RW    = rw;
        M68K_AS_n  = 1'b0;
        M68K_UDS_n = !uds;
        M68K_LDS_n = !lds;
    endtask

    // Edge 0 is the first rising edge after the inputs changed.
    task automatic wait_resp();
        resp     = 0;
        lat      = -1;
        oe_any   = 1'b0;
        both_low = 1'b0;
        oe_ack   = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge PI_CLK);
            #1;
            if (!M68K_DTACK_n && !M68K_BERR_n) both_low = 1'b1;
            if (M68K_D_OE) oe_any = 1'b1;
            if (!M68K_DTACK_n || !M68K_BERR_n) begin
                resp   = !M68K_DTACK_n ? 1 : 2;
                lat    = n;
                rdata  = M68K_D_OUT;
                oe_ack = M68K_D_OE;
                break;
            end
        end
    endtask

    // Keep AS_n low two more cycles (response must hold), then release and
    // measure how many edges until the bus is free again.
    task automatic end_cycle();
        held = 1'b1;
        if (resp != 0) begin
            repeat (2) begin
                @(posedge PI_CLK);
                #1;
                if (!M68K_DTACK_n && !M68K_BERR_n) both_low = 1'b1;
                if ((resp == 1) ? M68K_DTACK_n : M68K_BERR_n) held = 1'b0;
            end
        end
        @(negedge PI_CLK);
        M68K_AS_n  = 1'b1;
        M68K_UDS_n = 1'b1;
        M68K_LDS_n = 1'b1;
        M68K_RW    = 1'b1;
        rel = 99;
        for (int n = 0; n < 10; n++) begin
            @(posedge PI_CLK);
            #1;
            if (M68K_DTACK_n && M68K_BERR_n && !M68K_D_OE) begin
                rel = n;
                break;
            end
        end
        repeat (2) @(posedge PI_CLK);
    endtask

    task automatic access(input logic [23:0] addr, input logic rw,
                          input logic uds, input logic lds, input logic [15:0] wdata);
        drive_cycle(addr, rw, uds, lds, wdata);
        wait_resp();
        end_cycle();
    endtask

    initial begin
        RESET      = 1'b1;
        M68K_A     = '0;
        M68K_D_IN  = 16'h0000;
        M68K_AS_n  = 1'b1;
        M68K_UDS_n = 1'b1;
        M68K_LDS_n = 1'b1;
        M68K_RW    = 1'b1;
        exp_cnt    = 0;

        repeat (3) @(posedge PI_CLK);
        #1;
        check("rst_dtack", M68K_DTACK_n, 1'b1);
        check("rst_berr",  M68K_BERR_n, 1'b1);
        check("rst_oe",    M68K_D_OE, 1'b0);
        check("rst_dout",  M68K_D_OUT, 16'h0000);
        check("rst_cnt",   ACCESS_CNT, 16'h0000);
        @(negedge PI_CLK);
        RESET = 1'b0;
        repeat (2) @(posedge PI_CLK);

        // Word write then read at BASE+4 (index 2)
        access(BASE + 24'd4, 1'b0, 1'b1, 1'b1, 16'hA55A);
        exp_cnt++;
        check("wr_resp", resp, 1);
        check("wr_lat",  lat, 9);
        check("wr_oe",   oe_ack, 1'b0);
        check("wr_held", held, 1'b1);
        check("wr_cnt",  ACCESS_CNT, exp_cnt);

        access(BASE + 24'd4, 1'b1, 1'b1, 1'b1, 16'h0000);
        exp_cnt++;
        check("rd_resp", resp, 1);
        check("rd_lat",  lat, 9);
        check("rd_data", rdata, 16'hA55A);
        check("rd_oe",   oe_ack, 1'b1);
        check("rd_held", held, 1'b1);
        check("rd_rel",  rel <= 3, 1'b1);
        check("rd_cnt",  ACCESS_CNT, 16'd2);
        check("rd_excl", both_low, 1'b0);

        // Byte-lane writes on index 2
        access(BASE + 24'd4, 1'b0, 1'b1, 1'b1, 16'h0000);
        exp_cnt++;
        access(BASE + 24'd4, 1'b0, 1'b1, 1'b0, 16'h12FF);
        exp_cnt++;
        access(BASE + 24'd4, 1'b1, 1'b1, 1'b1, 16'h0000);
        exp_cnt++;
        check("uds_data", rdata, 16'h1200);
        access(BASE + 24'd4, 1'b0, 1'b0, 1'b1, 16'h34AB);
        exp_cnt++;
        access(BASE + 24'd4, 1'b1, 1'b0, 1'b1, 16'h0000);
        exp_cnt++;
        check("lds_data", rdata, 16'h12AB);
        check("lds_cnt",  ACCESS_CNT, exp_cnt);

        // Window misses: no response at all, counter untouched
        access(BASE + 24'd32, 1'b0, 1'b1, 1'b1, 16'h5A5A);
        check("miss_wr_resp", resp, 0);
        check("miss_wr_oe",   oe_any, 1'b0);
        access(BASE + 24'd32, 1'b1, 1'b1, 1'b1, 16'h0000);
        check("miss_rd_resp", resp, 0);
        check("miss_rd_oe",   oe_any, 1'b0);
        check("miss_cnt",     ACCESS_CNT, exp_cnt);
        access(BASE, 1'b1, 1'b1, 1'b1, 16'h0000);
        exp_cnt++;
        check("idx0_data", rdata, 16'h0000);

        // Top writable word, then index 2 must be untouched
        access(BASE + 24'd28, 1'b0, 1'b1, 1'b1, 16'hBEEF);
        exp_cnt++;
        access(BASE + 24'd28, 1'b1, 1'b1, 1'b1, 16'h0000);
        exp_cnt++;
        check("idx14_data", rdata, 16'hBEEF);
        access(BASE + 24'd4, 1'b1, 1'b1, 1'b1, 16'h0000);
        exp_cnt++;
        check("idx2_keep", rdata, 16'h12AB);

        // AS_n without data strobes: cycle aborted in STROBE
        access(BASE + 24'd4, 1'b1, 1'b0, 1'b0, 16'h0000);
        check("abort_resp", resp, 0);
        check("abort_cnt",  ACCESS_CNT, exp_cnt);

        // Protection violation on the ID word
        access(BASE + 24'd30, 1'b0, 1'b1, 1'b1, 16'hFFFF);
`ifdef M68K_RESP_BERR_EN
        check("prot_resp", resp, 2);
        check("prot_dtack_hi", both_low, 1'b0);
`else
        exp_cnt++;
        check("prot_resp", resp, 1);
`endif
        check("prot_held", held, 1'b1);
        check("prot_cnt",  ACCESS_CNT, exp_cnt);
        access(BASE + 24'd30, 1'b1, 1'b1, 1'b1, 16'h0000);
        exp_cnt++;
        check("id_data", rdata, 16'h5053);
        check("id_oe",   oe_ack, 1'b1);

        // Reset while acknowledging; AS_n stays low across reset
        drive_cycle(BASE + 24'd28, 1'b1, 1'b1, 1'b1, 16'h0000);
        wait_resp();
        check("pre_rst_resp", resp, 1);
        check("pre_rst_data", rdata, 16'hBEEF);
        @(negedge PI_CLK);
        RESET = 1'b1;
        @(posedge PI_CLK);
        #1;
        check("mid_rst_dtack", M68K_DTACK_n, 1'b1);
        check("mid_rst_oe",    M68K_D_OE, 1'b0);
        check("mid_rst_cnt",   ACCESS_CNT, 16'h0000);
        check("mid_rst_dout",  M68K_D_OUT, 16'h0000);
        @(negedge PI_CLK);
        RESET = 1'b0;
        wait_resp();
        check("post_rst_resp", resp, 1);
        check("post_rst_lat",  lat, 9);
        check("post_rst_data", rdata, 16'h0000);
        check("post_rst_cnt",  ACCESS_CNT, 16'd1);
        end_cycle();
        access(BASE, 1'b1, 1'b1, 1'b1, 16'h0000);
        check("post_rst_idx0", rdata, 16'h0000);
        check("post_rst_cnt2", ACCESS_CNT, 16'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
